// File: rtl/timer_pkg.sv
// timer_pkg: shared state encoding, default timing constants and level saturation helper
// for seq_channel_timer.
package timer_pkg;
    typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_t;
    localparam int DEF_VAL_MAX  = 15;
    localparam int DEF_CYC_FULL = 500_000;
    function automatic int sat_level(input int lvl, input int vmax);
        return lvl > vmax ? vmax : lvl;
    endfunction
endpackage

// File: rtl/seq_channel_timer_if.sv
// seq_channel_timer_if: control/status bundle of seq_channel_timer.
// The pause input exists only when PAUSE_EN is defined.
interface seq_channel_timer_if #(
    parameter int N_CH  = 3,
    parameter int VAL_W = 5
);
    localparam int CH_W = N_CH > 1 ? $clog2(N_CH) : 1;
    logic                  start;
    logic                  abort;
    logic [N_CH*VAL_W-1:0] val;
`ifdef PAUSE_EN
    logic                  pause;
`endif
    logic [N_CH-1:0]       ch_on;
    logic [N_CH-1:0]       flag;
    logic [CH_W-1:0]       cur_ch;
    logic                  busy;
    logic                  done;
    modport master (
`ifdef PAUSE_EN
        output pause,
`endif
        output start, abort, val,
        input  ch_on, flag, cur_ch, busy, done
    );
    modport slave (
`ifdef PAUSE_EN
        input  pause,
`endif
        input  start, abort, val,
        output ch_on, flag, cur_ch, busy, done
    );
endinterface

// File: rtl/level_to_cycles.sv
// level_to_cycles: saturates a level to VAL_MAX and scales it to CYC_FULL*lvl/VAL_MAX cycles,
// truncated, with the product held at CNT_W+VAL_W bits.
module level_to_cycles
    import timer_pkg::*;
#(
    parameter int VAL_W    = 5,
    parameter int VAL_MAX  = DEF_VAL_MAX,
    parameter int CYC_FULL = DEF_CYC_FULL,
    parameter int CNT_W    = 32
) (
    input  logic [VAL_W-1:0] lvl,
    output logic [CNT_W-1:0] cyc
);
    localparam int PW = CNT_W + VAL_W;
    logic [PW-1:0] prod;
    assign prod = PW'(CYC_FULL) * PW'(sat_level(32'(lvl), VAL_MAX));
    assign cyc  = CNT_W'(prod / PW'(VAL_MAX));
endmodule

// File: rtl/seq_channel_timer.sv
// seq_channel_timer: latches one level per channel, then enables each motor channel in turn
// for its scaled on-time. Define PAUSE_EN to add the pause input that stalls RUN.
module seq_channel_timer
    import timer_pkg::*;
#(
    parameter int N_CH     = 3,
    parameter int VAL_W    = 5,
    parameter int VAL_MAX  = DEF_VAL_MAX,
    parameter int CYC_FULL = DEF_CYC_FULL,
    parameter int CNT_W    = 32
) (
    input logic clk,
    input logic rst,
    seq_channel_timer_if.slave bus
);
    localparam int CH_W = N_CH > 1 ? $clog2(N_CH) : 1;
    localparam logic [CH_W-1:0] LAST = CH_W'(N_CH - 1);
    state_t          state, nxt;
    logic [CH_W-1:0] ch;
    logic [CNT_W-1:0] cnt, cyc, t_cur;
    logic [CNT_W-1:0] tbl [N_CH];
    logic [N_CH-1:0] fin, sel;
    logic            stall, zero, fin_now, adv, to_done, run_on;

    level_to_cycles #(.VAL_W(VAL_W), .VAL_MAX(VAL_MAX), .CYC_FULL(CYC_FULL), .CNT_W(CNT_W)) u_l2c (
        .lvl(bus.val[int'(ch)*VAL_W +: VAL_W]),
        .cyc(cyc)
    );

`ifdef PAUSE_EN
    assign stall = bus.pause && state == RUN;
`else
    assign stall = 1'b0;
`endif
    assign t_cur   = tbl[ch];
    assign sel     = N_CH'(1) << ch;
    assign zero    = t_cur == '0;
    assign run_on  = state == RUN && !stall;
    assign fin_now = run_on && !zero && cnt == t_cur - CNT_W'(1);
    assign adv     = run_on && (zero || fin_now);
    // a skipped final channel folds into the DONE cycle, which already carries its flag
    assign to_done = ch == LAST || (int'(ch) == N_CH - 2 && tbl[N_CH-1] == '0);

    always_comb begin
        nxt = state;
        case (state)
            IDLE: nxt = bus.start ? LOAD : IDLE;
            LOAD: nxt = ch != LAST ? LOAD : (N_CH == 1 && cyc == '0) ? DONE : RUN;
            RUN:  nxt = !adv ? RUN : to_done ? DONE : RUN;
            DONE: nxt = IDLE;
        endcase
        if (bus.abort) nxt = IDLE;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            ch    <= '0;
            cnt   <= '0;
            fin   <= '0;
            for (int k = 0; k < N_CH; k++) tbl[k] <= '0;
        end else begin
            state <= nxt;
            ch    <= nxt == IDLE ? '0 :
                     state == LOAD ? (ch == LAST ? '0 : ch + CH_W'(1)) :
                     (adv && ch != LAST) ? ch + CH_W'(1) : ch;
            cnt   <= (state != RUN || adv) ? '0 : stall ? cnt : cnt + CNT_W'(1);
            fin   <= fin_now && !bus.abort ? sel : '0;
            for (int k = 0; k < N_CH; k++) if (state == LOAD && ch == CH_W'(k)) tbl[k] <= cyc;
        end
    end

    assign bus.ch_on  = sel & {N_CH{run_on && !zero}};
    assign bus.flag   = fin | (sel & {N_CH{run_on && zero}}) | (N_CH'(state == DONE) << LAST);
    assign bus.cur_ch = ch;
    assign bus.busy   = state != IDLE;
    assign bus.done   = state == DONE;
endmodule

// File: tb/tb_seq_channel_timer.sv
// tb_seq_channel_timer: randomized and directed stimulus against a cycle-timeline model
// built from the channel on-time rules (N_CH=3, VAL_MAX=15, CYC_FULL=30).
module tb_seq_channel_timer;
    localparam int N = 3, W = 5, VMAX = 15, CF = 30, MAXL = 160;
    logic clk = 1'b0, rst;
    always #5 clk = ~clk;

    seq_channel_timer_if #(.N_CH(N), .VAL_W(W)) bus ();
    seq_channel_timer #(.N_CH(N), .VAL_W(W), .VAL_MAX(VMAX), .CYC_FULL(CF), .CNT_W(32)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int n_vec = 0, n_err = 0, cur_t = -1;
    int p0 = 0, plen = 0, td = 0;
    logic [N-1:0] e_on [MAXL];
    logic [N-1:0] e_fl [MAXL];
    logic         e_busy [MAXL];
    logic         e_done [MAXL];
    int           e_cur [MAXL];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s t=%0d: got %0h, expected %0h", tag, cur_t, got, exp);
        end
    endtask

    function automatic bit paused(input int t);
        return t >= p0 && t < p0 + plen;
    endfunction

    // Expected outputs per cycle; cycle 0 is the IDLE cycle in which start is high.
    task automatic gen(input logic [N*W-1:0] vv);
        int tt [N];
        int t, n;
        for (int i = 0; i < MAXL; i++) begin
            e_on[i] = '0; e_fl[i] = '0; e_busy[i] = 1'b0; e_done[i] = 1'b0; e_cur[i] = 0;
        end
        for (int k = 0; k < N; k++) begin
            n = int'(vv[k*W +: W]);
            tt[k] = CF * (n > VMAX ? VMAX : n) / VMAX;
        end
        for (t = 1; t <= N; t++) e_cur[t] = t - 1;
        for (int k = 0; k < N; k++) begin
            if (tt[k] == 0 && k == N - 1) break;
            if (tt[k] == 0) begin
                while (paused(t)) begin e_cur[t] = k; t++; end
                e_cur[t] = k; e_fl[t][k] = 1'b1; t++;
            end else begin
                n = 0;
                while (n < tt[k]) begin
                    e_cur[t] = k;
                    if (!paused(t)) begin e_on[t][k] = 1'b1; n++; end
                    t++;
                end
                e_fl[t][k] = 1'b1;
            end
        end
        td = t;
        e_done[td] = 1'b1; e_fl[td][N-1] = 1'b1; e_cur[td] = N - 1;
        for (int i = 1; i <= td; i++) e_busy[i] = 1'b1;
    endtask

    // ab: <0 no abort, 0 random abort cycle, >0 abort in that cycle
    task automatic run_seq(input logic [N*W-1:0] vv, input int ab, input int pp0, input int pl,
                           input bit hold, output int done_t, output int on0);
        int abort_at, last;
        p0 = pp0; plen = pl;
`ifndef PAUSE_EN
        plen = 0;
`endif
        gen(vv);
        abort_at = ab < 0 ? -1 : ab == 0 ? int'($urandom_range(td, 1)) : ab;
        if (abort_at >= 0)
            for (int i = abort_at + 1; i < MAXL; i++) begin
                e_on[i] = '0; e_fl[i] = '0; e_busy[i] = 1'b0; e_done[i] = 1'b0; e_cur[i] = 0;
            end
        last = abort_at >= 0 ? abort_at : td;
        done_t = -1; on0 = 0;
        for (int t = 0; t <= last + 2; t++) begin
            bus.start = (t == 0) || (t <= last && (hold || $urandom_range(7, 0) == 0));
            bus.abort = t == abort_at;
            bus.val   = (t >= 1 && t <= N) ? vv : (N*W)'($urandom);
`ifdef PAUSE_EN
            bus.pause = paused(t);
`endif
            @(negedge clk);
            cur_t = t;
            chk("ch_on", 32'(bus.ch_on), 32'(e_on[t]));
            chk("flag", 32'(bus.flag), 32'(e_fl[t]));
            chk("busy", 32'(bus.busy), 32'(e_busy[t]));
            chk("done", 32'(bus.done), 32'(e_done[t]));
            chk("cur_ch", 32'(bus.cur_ch), 32'(e_cur[t]));
            if (bus.done && done_t < 0) done_t = t;
            if (bus.ch_on[0]) on0++;
            @(posedge clk); #1;
        end
        bus.start = 1'b0; bus.abort = 1'b0;
`ifdef PAUSE_EN
        bus.pause = 1'b0;
`endif
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_ch_on"}, 32'(bus.ch_on), 32'd0);
        chk({tag, "_flag"}, 32'(bus.flag), 32'd0);
        chk({tag, "_cur_ch"}, 32'(bus.cur_ch), 32'd0);
        chk({tag, "_busy"}, 32'(bus.busy), 32'd0);
        chk({tag, "_done"}, 32'(bus.done), 32'd0);
    endtask

    initial begin
        int d, o;
        logic [N*W-1:0] rv;
        rst = 1'b1; bus.start = 1'b0; bus.abort = 1'b0; bus.val = '0;
`ifdef PAUSE_EN
        bus.pause = 1'b0;
`endif
        repeat (2) @(posedge clk);
        #1 chk_idle("reset");
        @(negedge clk) rst = 1'b0;
        @(posedge clk); #1;

        run_seq({5'd15, 5'd10, 5'd5}, -1, 0, 0, 0, d, o);
        chk("t1_done_at", 32'(d), 32'd64); chk("t1_on0", 32'(o), 32'd10);
        run_seq({5'd0, 5'd15, 5'd0}, -1, 0, 0, 0, d, o);
        chk("t2_done_at", 32'(d), 32'd35); chk("t2_on0", 32'(o), 32'd0);
        run_seq({5'd0, 5'd0, 5'd31}, -1, 0, 0, 0, d, o);
        chk("t3_sat_done_at", 32'(d), 32'd35); chk("t3_sat_on0", 32'(o), 32'd30);
        run_seq({5'd0, 5'd0, 5'd1}, -1, 0, 0, 0, d, o);
        chk("t3_min_done_at", 32'(d), 32'd7); chk("t3_min_on0", 32'(o), 32'd2);
        run_seq({5'd15, 5'd10, 5'd5}, 19, 0, 0, 0, d, o);
        chk("t4_abort_done", 32'(d), 32'hffffffff);
        run_seq({5'd15, 5'd10, 5'd5}, -1, 0, 0, 0, d, o);
        chk("t4_rerun_done_at", 32'(d), 32'd64);
        run_seq({5'd15, 5'd10, 5'd5}, -1, 0, 0, 1, d, o);
        chk("t5_hold_done_at", 32'(d), 32'd64);
`ifdef PAUSE_EN
        run_seq({5'd0, 5'd0, 5'd5}, -1, 6, 7, 0, d, o);
        chk("t6_pause_done_at", 32'(d), 32'd22); chk("t6_pause_on0", 32'(o), 32'd10);
`endif

        cur_t = -1;
        bus.val = {5'd15, 5'd10, 5'd5}; bus.start = 1'b1;
        @(posedge clk); #1 bus.start = 1'b0;
        repeat (8) @(posedge clk);
        #1 chk("rst_pre_ch_on", 32'(bus.ch_on), 32'd1);
        chk("rst_pre_busy", 32'(bus.busy), 32'd1);
        #1 rst = 1'b1;
        #1 chk_idle("rst_async");
        @(negedge clk) rst = 1'b0;
        @(posedge clk); #1;

        for (int i = 0; i < 30; i++) begin
            for (int k = 0; k < N; k++)
                rv[k*W +: W] = ($urandom_range(3, 0) == 0) ? 5'd0 : 5'($urandom_range(31, 0));
            run_seq(rv, ($urandom_range(3, 0) == 0) ? 0 : -1, int'($urandom_range(60, 0)),
                    int'($urandom_range(12, 0)), $urandom_range(4, 0) == 0, d, o);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
